sram_tp_regfile: RTL and testbench



---
 rtl/sram_tp_regfile_pkg.sv | 13 +
 rtl/sram_tp_regfile.sv | 82 ++++++++
 tb/tb_sram_tp_regfile.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_tp_regfile_pkg.sv
// sram_tp_regfile_pkg
//   Shared helpers for the register-file memory.
//   func_log2 : ceil(log2(n)). This is the address width needed to index n entries.
package sram_tp_regfile_pkg;

   function automatic int unsigned func_log2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/sram_tp_regfile.sv
// sram_tp_regfile
//   Two-port (1W/1R) flip-flop based memory for small on-chip buffers.
//   KNOB_REGOUT=0 gives a combinational read. KNOB_REGOUT=1 adds an output register,
//   which adds one cycle of read latency.
//   Out-of-range writes are dropped. Out-of-range reads return 0.
//   A read and a write to the same address in one cycle read the old contents.
// Ports
//   clk, rstn              : clock and asynchronous active-low reset
//   wr_val_i/adr_i/dat_i   : write enable, write address, write data
//   rd_val_i/adr_i         : read request, read address
//   rd_val_o/dat_o         : read valid, read data
module sram_tp_regfile
   import sram_tp_regfile_pkg::*;
#(
   parameter int unsigned KNOB_REGOUT = 0,
   parameter int unsigned SIZE        = 16,
   parameter int unsigned DATA_WD     = 32,
   localparam int unsigned SIZE_WD    = func_log2(SIZE)
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               wr_val_i,
   input  logic [SIZE_WD-1:0] wr_adr_i,
   input  logic [DATA_WD-1:0] wr_dat_i,
   input  logic               rd_val_i,
   input  logic [SIZE_WD-1:0] rd_adr_i,
   output logic               rd_val_o,
   output logic [DATA_WD-1:0] rd_dat_o
);

   logic [DATA_WD-1:0] w_mem [SIZE];
   logic [DATA_WD-1:0] w_rd_dat;

   // Each entry decodes its own address. An address >= SIZE matches no entry,
   // so that write is dropped without an explicit range check.
   for (genvar g = 0; g < SIZE; g++) begin : g_ent
      logic [DATA_WD-1:0] r_ent;
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn)
            r_ent <= '0;
         else if (wr_val_i && (wr_adr_i == SIZE_WD'(g)))
            r_ent <= wr_dat_i;
      end
      assign w_mem[g] = r_ent;
   end

   // The read mux defaults to zero, so an unmatched (out-of-range) address returns 0.
   always_comb begin
      w_rd_dat = '0;
      for (int unsigned i = 0; i < SIZE; i++)
         if (rd_adr_i == SIZE_WD'(i)) w_rd_dat = w_mem[i];
   end

   if (KNOB_REGOUT == 0) begin : g_rd_comb
      assign rd_val_o = rd_val_i;
      assign rd_dat_o = w_rd_dat;
   end else begin : g_rd_reg
      logic               r_rd_val;
      logic [DATA_WD-1:0] r_rd_dat;
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            r_rd_val <= 1'b0;
            r_rd_dat <= '0;
         end else begin
            r_rd_val <= rd_val_i;
            if (rd_val_i) r_rd_dat <= w_rd_dat;
         end
      end
      assign rd_val_o = r_rd_val;
      assign rd_dat_o = r_rd_dat;
   end

`ifdef SIM_KNOB_DBG
   always_ff @(posedge clk) begin
      if (rstn) begin
         assert (!wr_val_i || (32'(wr_adr_i) < SIZE));
         assert (!rd_val_i || (32'(rd_adr_i) < SIZE));
      end
   end
`endif

endmodule

// File: tb/tb_sram_tp_regfile.sv
// tb_sram_tp_regfile
//   Self-checking bench. It has two 16x32 instances (comb/registered read) that
//   share one stimulus group, and two 5x32 instances that share another.
//   A behavioural model (arrays + expected output register) is checked every cycle.
//   Directed sequences also check hand-computed literal values.
module tb_sram_tp_regfile;

   logic clk = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   // group A: SIZE=16
   logic        a_wv = 1'b0, a_rv = 1'b0;
   logic [3:0]  a_wa = '0, a_ra = '0;
   logic [31:0] a_wd = '0;
   logic        a0_val, a1_val;
   logic [31:0] a0_dat, a1_dat;
   // group B: SIZE=5
   logic        b_wv = 1'b0, b_rv = 1'b0;
   logic [2:0]  b_wa = '0, b_ra = '0;
   logic [31:0] b_wd = '0;
   logic        b0_val, b1_val;
   logic [31:0] b0_dat, b1_dat;

   sram_tp_regfile #(.KNOB_REGOUT(0), .SIZE(16), .DATA_WD(32)) dA0 (
      .clk(clk), .rstn(rstn), .wr_val_i(a_wv), .wr_adr_i(a_wa), .wr_dat_i(a_wd),
      .rd_val_i(a_rv), .rd_adr_i(a_ra), .rd_val_o(a0_val), .rd_dat_o(a0_dat));
   sram_tp_regfile #(.KNOB_REGOUT(1), .SIZE(16), .DATA_WD(32)) dA1 (
      .clk(clk), .rstn(rstn), .wr_val_i(a_wv), .wr_adr_i(a_wa), .wr_dat_i(a_wd),
      .rd_val_i(a_rv), .rd_adr_i(a_ra), .rd_val_o(a1_val), .rd_dat_o(a1_dat));
   sram_tp_regfile #(.KNOB_REGOUT(0), .SIZE(5), .DATA_WD(32)) dB0 (
      .clk(clk), .rstn(rstn), .wr_val_i(b_wv), .wr_adr_i(b_wa), .wr_dat_i(b_wd),
      .rd_val_i(b_rv), .rd_adr_i(b_ra), .rd_val_o(b0_val), .rd_dat_o(b0_dat));
   sram_tp_regfile #(.KNOB_REGOUT(1), .SIZE(5), .DATA_WD(32)) dB1 (
      .clk(clk), .rstn(rstn), .wr_val_i(b_wv), .wr_adr_i(b_wa), .wr_dat_i(b_wd),
      .rd_val_i(b_rv), .rd_adr_i(b_ra), .rd_val_o(b1_val), .rd_dat_o(b1_dat));

   int n_pass = 0;
   int n_tot  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] mA [16];
   logic [31:0] mB [5];
   logic        eA_val, eB_val;
   logic [31:0] eA_dat, eB_dat;

   function automatic logic [31:0] rdA(input logic [3:0] a);
      return mA[a];
   endfunction
   function automatic logic [31:0] rdB(input logic [2:0] a);
      return (a < 3'd5) ? mB[a] : 32'h0;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 16; i++) mA[i] <= '0;
         for (int i = 0; i < 5; i++)  mB[i] <= '0;
         eA_val <= 1'b0; eA_dat <= '0;
         eB_val <= 1'b0; eB_dat <= '0;
      end else begin
         eA_val <= a_rv;
         if (a_rv) eA_dat <= rdA(a_ra);
         eB_val <= b_rv;
         if (b_rv) eB_dat <= rdB(b_ra);
         if (a_wv) mA[a_wa] <= a_wd;
         if (b_wv && b_wa < 3'd5) mB[b_wa] <= b_wd;
      end
   end

   always @(negedge clk) begin
      check("A0.val", 32'(a0_val), 32'(a_rv));
      check("A0.dat", a0_dat, rdA(a_ra));
      check("A1.val", 32'(a1_val), 32'(eA_val));
      check("A1.dat", a1_dat, eA_dat);
      check("B0.val", 32'(b0_val), 32'(b_rv));
      check("B0.dat", b0_dat, rdB(b_ra));
      check("B1.val", 32'(b1_val), 32'(eB_val));
      check("B1.dat", b1_dat, eB_dat);
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   logic [31:0] q0[$];
   logic [31:0] q1[$];

   initial begin
      #1 rstn = 1'b0;
      repeat (2) @(posedge clk);
      #2 rstn = 1'b1;
      #1;
      check("rst_a1_val", 32'(a1_val), 32'h0);
      check("rst_b1_val", 32'(b1_val), 32'h0);
      #1;

      // reset then read all addresses
      for (int a = 0; a <= 16; a++) begin
         if (a > 0) begin
            check("rst_rd_a1_val", 32'(a1_val), 32'h1);
            check("rst_rd_a1_dat", a1_dat, 32'h0);
         end
         if (a < 16) begin
            a_rv = 1'b1; a_ra = 4'(a);
            #1;
            check("rst_rd_a0_dat", a0_dat, 32'h0);
            if (a == 0) check("rst_a1_val_pre", 32'(a1_val), 32'h0);
            cyc();
         end
      end
      a_rv = 1'b0;

      // write pattern, then read back
      for (int a = 0; a < 16; a++) begin
         a_wv = 1'b1; a_wa = 4'(a); a_wd = 32'hA5A5_0000 + 32'(a);
         cyc();
      end
      a_wv = 1'b0;
      for (int a = 0; a <= 16; a++) begin
         if (a > 0) begin
            check("wr_rd_a1_val", 32'(a1_val), 32'h1);
            check("wr_rd_a1_dat", a1_dat, 32'hA5A5_0000 + 32'(a - 1));
         end
         if (a < 16) begin
            a_rv = 1'b1; a_ra = 4'(a);
            #1;
            check("wr_rd_a0_dat", a0_dat, 32'hA5A5_0000 + 32'(a));
            cyc();
         end
      end
      a_rv = 1'b0;
      cyc();
      check("hold_a1_val", 32'(a1_val), 32'h0);
      check("hold_a1_dat", a1_dat, 32'hA5A5_000F);

      // same-address collision
      a_wv = 1'b1; a_wa = 4'd3; a_wd = 32'h1111;
      cyc();
      a_wd = 32'h2222; a_rv = 1'b1; a_ra = 4'd3;
      #1;
      check("coll_a0_old", a0_dat, 32'h1111);
      cyc();
      check("coll_a1_old", a1_dat, 32'h1111);
      a_wv = 1'b0;
      #1;
      check("coll_a0_new", a0_dat, 32'h2222);
      cyc();
      check("coll_a1_new", a1_dat, 32'h2222);
      a_rv = 1'b0;

      // SIZE=5: out-of-range write is dropped, out-of-range read gives 0
      for (int a = 0; a < 5; a++) begin
         b_wv = 1'b1; b_wa = 3'(a); b_wd = 32'hB000 + 32'(a);
         cyc();
      end
      b_wa = 3'd6; b_wd = 32'hDEAD;
      cyc();
      b_wv = 1'b0; b_rv = 1'b1; b_ra = 3'd6;
      #1;
      check("oor_b0_dat", b0_dat, 32'h0);
      cyc();
      check("oor_b1_dat", b1_dat, 32'h0);
      b_ra = 3'd5;
      #1;
      check("oor5_b0_dat", b0_dat, 32'h0);
      for (int a = 0; a < 5; a++) begin
         b_ra = 3'(a);
         #1;
         check("oor_keep_b0", b0_dat, 32'hB000 + 32'(a));
         cyc();
      end
      b_rv = 1'b0;
      cyc();

      // full-rate streaming at distance 2, pointers wrapping 4->0
      for (int k = 0; k < 22; k++) begin
         b_wv = (k < 20);
         b_wa = 3'(k % 5);
         b_wd = 32'h5000_0000 + 32'(k);
         b_rv = (k >= 2);
         b_ra = 3'((k + 3) % 5);
         #1;
         if (k >= 2) q0.push_back(b0_dat);
         cyc();
         if (k >= 2) begin
            check("strm_b1_val", 32'(b1_val), 32'h1);
            q1.push_back(b1_dat);
         end
      end
      b_wv = 1'b0; b_rv = 1'b0;
      check("strm_q0_len", 32'(q0.size()), 32'd20);
      check("strm_q1_len", 32'(q1.size()), 32'd20);
      for (int k = 0; k < 20; k++) begin
         check("strm_q0", (k < q0.size()) ? q0[k] : 32'hX, 32'h5000_0000 + 32'(k));
         check("strm_q1", (k < q1.size()) ? q1[k] : 32'hX, 32'h5000_0000 + 32'(k));
      end
      cyc();

      // asynchronous reset while a registered read is in flight
      a_rv = 1'b1; a_ra = 4'd5;
      cyc();
      check("ar_pre_val", 32'(a1_val), 32'h1);
      check("ar_pre_dat", a1_dat, 32'hA5A5_0005);
      a_ra = 4'd6;
      #1 rstn = 1'b0;
      #1;
      check("ar_a1_val", 32'(a1_val), 32'h0);
      check("ar_a1_dat", a1_dat, 32'h0);
      check("ar_a0_dat", a0_dat, 32'h0);
      @(posedge clk);
      #2 rstn = 1'b1;
      for (int a = 0; a <= 16; a++) begin
         if (a > 0) check("ar_post_a1", a1_dat, 32'h0);
         if (a < 16) begin
            a_ra = 4'(a);
            #1;
            check("ar_post_a0", a0_dat, 32'h0);
            cyc();
         end
      end
      a_rv = 1'b0;
      for (int a = 0; a < 5; a++) begin
         b_rv = 1'b1; b_ra = 3'(a);
         #1;
         check("ar_post_b0", b0_dat, 32'h0);
         cyc();
      end
      b_rv = 1'b0;
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
